// File: rtl/hci_package.sv
// Shared HCI core defaults and types used by the interface and the width-adapting stages.
package hci_package;

    localparam int unsigned DEFAULT_DW = 32;
    localparam int unsigned DEFAULT_AW = 32;
    localparam int unsigned DEFAULT_BW = 8;
    localparam int unsigned DEFAULT_UW = 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } hci_serializer_state_e;

endpackage

// File: rtl/hci_core_intf.sv
// HCI core request/response bundle; a zero user width is carried as one unused bit.
interface hci_core_intf #(
    parameter int unsigned DW = hci_package::DEFAULT_DW,
    parameter int unsigned AW = hci_package::DEFAULT_AW,
    parameter int unsigned BW = hci_package::DEFAULT_BW,
    parameter int unsigned UW = hci_package::DEFAULT_UW
);
    localparam int unsigned UWE = (UW > 0) ? UW : 1;

    logic             req;
    logic             gnt;
    logic [AW-1:0]    add;
    logic             wen;
    logic [DW-1:0]    data;
    logic [DW/BW-1:0] be;
    logic [DW/BW-1:0] boffs;
    logic [UWE-1:0]   user;
    logic             lrdy;
    logic [DW-1:0]    r_data;
    logic             r_valid;
    logic [UWE-1:0]   r_user;

    modport master (
        output req, add, wen, data, be, boffs, user, lrdy,
        input  gnt, r_data, r_valid, r_user
    );

    modport slave (
        input  req, add, wen, data, be, boffs, user, lrdy,
        output gnt, r_data, r_valid, r_user
    );

endinterface

// File: rtl/hci_core_serializer.sv
// Splits one wide HCI core request into N narrow beats and gathers the N narrow
// responses back into one wide response, with a bounded number of wide transactions in flight.
module hci_core_serializer
    import hci_package::*;
#(
    parameter int unsigned DW_IN           = 128,
    parameter int unsigned DW_OUT          = hci_package::DEFAULT_DW,
    parameter int unsigned BW              = hci_package::DEFAULT_BW,
    parameter int unsigned AW              = hci_package::DEFAULT_AW,
    parameter int unsigned UW              = hci_package::DEFAULT_UW,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    output logic         busy_o,
    hci_core_intf.slave  tcdm_slave,
    hci_core_intf.master tcdm_master
);

    localparam int unsigned N          = DW_IN / DW_OUT;
    localparam int unsigned BEAT_BYTES = DW_OUT / 8;
    localparam int unsigned BE_IN      = DW_IN / BW;
    localparam int unsigned BE_OUT     = DW_OUT / BW;
    localparam int unsigned UWE        = (UW > 0) ? UW : 1;
    localparam int unsigned CW         = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned OW         = $clog2(MAX_OUTSTANDING + 1);

    if (N == 1) begin : gen_passthrough
        assign tcdm_master.req    = tcdm_slave.req;
        assign tcdm_master.add    = tcdm_slave.add;
        assign tcdm_master.wen    = tcdm_slave.wen;
        assign tcdm_master.data   = tcdm_slave.data;
        assign tcdm_master.be     = tcdm_slave.be;
        assign tcdm_master.boffs  = tcdm_slave.boffs;
        assign tcdm_master.user   = tcdm_slave.user;
        assign tcdm_master.lrdy   = tcdm_slave.lrdy;
        assign tcdm_slave.gnt     = tcdm_master.gnt;
        assign tcdm_slave.r_data  = tcdm_master.r_data;
        assign tcdm_slave.r_valid = tcdm_master.r_valid;
        assign tcdm_slave.r_user  = tcdm_master.r_user;
        assign busy_o             = tcdm_slave.req;
    end else begin : gen_serial
        hci_serializer_state_e     state_q, state_d;
        logic [CW-1:0]             beat_q, beat_d;
        logic [CW-1:0]             rsp_cnt_q;
        logic [OW-1:0]             out_cnt_q;
        logic [AW-1:0]             req_add_q;
        logic [DW_IN-1:0]          req_data_q;
        logic [BE_IN-1:0]          req_be_q;
        logic                      req_wen_q;
        logic [UWE-1:0]            req_user_q;
        logic [(N-1)*DW_OUT-1:0]   collect_q;
        logic [DW_IN-1:0]          out_data_q;
        logic [UWE-1:0]            out_user_q;
        logic                      out_valid_q;
        logic                      slave_gnt, capture, master_lrdy;
        logic                      rsp_accept, rsp_last, out_inc, out_dec;
        logic                      unused_boffs;

        always_comb begin
            state_d   = state_q;
            beat_d    = beat_q;
            slave_gnt = 1'b0;
            capture   = 1'b0;
            case (state_q)
                IDLE: begin
                    slave_gnt = tcdm_slave.req & (out_cnt_q < OW'(MAX_OUTSTANDING));
                    if (slave_gnt) begin
                        capture = 1'b1;
                        beat_d  = '0;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (tcdm_master.gnt) begin
                        if (beat_q == CW'(N - 1)) begin
                            beat_d  = '0;
                            state_d = IDLE;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q    <= IDLE;
                beat_q     <= '0;
                req_add_q  <= '0;
                req_data_q <= '0;
                req_be_q   <= '0;
                req_wen_q  <= 1'b0;
                req_user_q <= '0;
            end else if (clear_i) begin
                state_q    <= IDLE;
                beat_q     <= '0;
                req_add_q  <= '0;
                req_data_q <= '0;
                req_be_q   <= '0;
                req_wen_q  <= 1'b0;
                req_user_q <= '0;
            end else begin
                state_q <= state_d;
                beat_q  <= beat_d;
                if (capture) begin
                    req_add_q  <= tcdm_slave.add;
                    req_data_q <= tcdm_slave.data;
                    req_be_q   <= tcdm_slave.be;
                    req_wen_q  <= tcdm_slave.wen;
                    req_user_q <= tcdm_slave.user;
                end
            end
        end

        // The last beat goes straight into out_data_q, so collect_q only holds beats 0..N-2.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rsp_cnt_q   <= '0;
                collect_q   <= '0;
                out_data_q  <= '0;
                out_user_q  <= '0;
                out_valid_q <= 1'b0;
            end else if (clear_i) begin
                rsp_cnt_q   <= '0;
                collect_q   <= '0;
                out_data_q  <= '0;
                out_user_q  <= '0;
                out_valid_q <= 1'b0;
            end else begin
                if (rsp_accept) begin
                    if (rsp_last) begin
                        rsp_cnt_q  <= '0;
                        out_data_q <= {tcdm_master.r_data, collect_q};
                        out_user_q <= tcdm_master.r_user;
                    end else begin
                        rsp_cnt_q <= rsp_cnt_q + 1'b1;
                        collect_q[32'(rsp_cnt_q)*DW_OUT +: DW_OUT] <= tcdm_master.r_data;
                    end
                end
                if (rsp_last) begin
                    out_valid_q <= 1'b1;
                end else if (tcdm_slave.lrdy) begin
                    out_valid_q <= 1'b0;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                out_cnt_q <= '0;
            end else if (clear_i) begin
                out_cnt_q <= '0;
            end else if (out_inc && !out_dec) begin
                out_cnt_q <= out_cnt_q + 1'b1;
            end else if (out_dec && !out_inc) begin
                out_cnt_q <= out_cnt_q - 1'b1;
            end
        end

        assign master_lrdy = ~out_valid_q | tcdm_slave.lrdy;
        assign rsp_accept  = tcdm_master.r_valid & master_lrdy;
        assign rsp_last    = rsp_accept & (rsp_cnt_q == CW'(N - 1));
        assign out_inc     = slave_gnt;
        assign out_dec     = out_valid_q & tcdm_slave.lrdy;

        assign tcdm_slave.gnt     = slave_gnt;
        assign tcdm_slave.r_valid = out_valid_q;
        assign tcdm_slave.r_data  = out_data_q;
        assign tcdm_slave.r_user  = out_user_q;

        assign tcdm_master.req   = (state_q == ISSUE);
        assign tcdm_master.add   = req_add_q + AW'(32'(beat_q) * BEAT_BYTES);
        assign tcdm_master.wen   = req_wen_q;
        assign tcdm_master.data  = req_data_q[32'(beat_q)*DW_OUT +: DW_OUT];
        assign tcdm_master.be    = req_be_q[32'(beat_q)*BE_OUT +: BE_OUT];
        assign tcdm_master.boffs = '0;
        assign tcdm_master.user  = req_user_q;
        assign tcdm_master.lrdy  = master_lrdy;

        assign busy_o       = (state_q != IDLE) | (out_cnt_q != '0);
        assign unused_boffs = ^tcdm_slave.boffs;

`ifndef SYNTHESIS
        always @(posedge clk_i) begin
            if (rst_ni && !clear_i) begin
                assert (!(tcdm_master.r_valid && (out_cnt_q == '0)))
                    else $error("hci_core_serializer: downstream response with nothing outstanding");
            end
        end
`endif
    end

endmodule

// File: tb/tb_hci_core_serializer.sv
// Directed bench for hci_core_serializer with a 128-bit slave side and a 32-bit master side.
module tb_hci_core_serializer;

    logic clk_i;
    logic rst_ni;
    logic clear_i;
    logic busy_o;
    int   checks;
    int   errors;

    hci_core_intf #(.DW(128), .AW(32), .BW(8), .UW(0)) s_if ();
    hci_core_intf #(.DW(32),  .AW(32), .BW(8), .UW(0)) m_if ();

    hci_core_serializer #(
        .DW_IN          (128),
        .DW_OUT         (32),
        .BW             (8),
        .AW             (32),
        .UW             (0),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .busy_o     (busy_o),
        .tcdm_slave (s_if),
        .tcdm_master(m_if)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
            end
    endtask

    task automatic request(input logic [31:0] add, input logic wen, input logic [127:0] data,
                           input logic [15:0] be);
        @(negedge clk_i);
        s_if.req  = 1'b1;
        s_if.add  = add;
        s_if.wen  = wen;
        s_if.data = data;
        s_if.be   = be;
        #1;
        check_output("slave_gnt", s_if.gnt, 1'b1);
    endtask

    task automatic check_beats(input logic [31:0] base, input logic [127:0] data,
                               input logic [15:0] be, input logic wen, input logic hold);
        logic [31:0] exp_add;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            s_if.req = hold;
            #1;
            exp_add = base + 32'(4 * i);
            check_output("beat_req", m_if.req, 1'b1);
            check_output("beat_add", m_if.add, exp_add);
            check_output("beat_data", m_if.data, data[i*32 +: 32]);
            check_output("beat_be", m_if.be, be[i*4 +: 4]);
            check_output("beat_wen", m_if.wen, wen);
            check_output("gnt_in_issue", s_if.gnt, 1'b0);
            check_output("busy_in_issue", busy_o, 1'b1);
        end
    endtask

    task automatic respond_beats(input logic [127:0] rsp);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            m_if.r_valid = 1'b1;
            m_if.r_data  = rsp[i*32 +: 32];
            #1;
            check_output("rsp_lrdy", m_if.lrdy, 1'b1);
            check_output("early_r_valid", s_if.r_valid, 1'b0);
        end
        @(negedge clk_i);
        m_if.r_valid = 1'b0;
        #1;
        check_output("wide_r_valid", s_if.r_valid, 1'b1);
        check_output("wide_r_data", s_if.r_data, rsp);
    endtask

    task automatic single_read(input logic [31:0] add, input logic [127:0] rsp);
        request(add, 1'b1, '0, 16'hFFFF);
        check_beats(add, '0, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk_i);
        #1;
        check_output("req_after_beats", m_if.req, 1'b0);
        respond_beats(rsp);
        @(negedge clk_i);
        #1;
        check_output("r_valid_single_pulse", s_if.r_valid, 1'b0);
        check_output("busy_after_read", busy_o, 1'b0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_ni       = 1'b0;
        clear_i      = 1'b0;
        s_if.req     = 1'b0;
        s_if.add     = '0;
        s_if.wen     = 1'b1;
        s_if.data    = '0;
        s_if.be      = '0;
        s_if.boffs   = '0;
        s_if.user    = '0;
        s_if.lrdy    = 1'b1;
        m_if.gnt     = 1'b1;
        m_if.r_valid = 1'b0;
        m_if.r_data  = '0;
        m_if.r_user  = '0;

        #1;
        check_output("rst_slave_gnt", s_if.gnt, 1'b0);
        check_output("rst_r_valid", s_if.r_valid, 1'b0);
        check_output("rst_r_data", s_if.r_data, '0);
        check_output("rst_master_req", m_if.req, 1'b0);
        check_output("rst_master_lrdy", m_if.lrdy, 1'b1);
        check_output("rst_busy", busy_o, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single read with four distinct beat responses
        single_read(32'h0000_0100, 128'h0000000D_0000000C_0000000B_0000000A);

        // Write with only beat 1 enabled; every beat still issues and answers
        request(32'h0000_0200, 1'b0, 128'h44444444_33333333_22222222_11111111, 16'h00F0);
        check_beats(32'h0000_0200, 128'h44444444_33333333_22222222_11111111, 16'h00F0, 1'b0, 1'b0);
        respond_beats('0);
        @(negedge clk_i);
        #1;
        check_output("write_r_valid_pulse", s_if.r_valid, 1'b0);
        s_if.wen = 1'b1;

        // Toggling downstream grant; slave request held high through ISSUE
        request(32'h0000_0300, 1'b1, 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, 16'hFFFF);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk_i);
            m_if.gnt = ((c % 2) == 0);
            #1;
            check_output("toggle_req", m_if.req, 1'b1);
            check_output("toggle_add", m_if.add, 32'h0000_0300 + 32'(4 * ((c + 1) / 2)));
            case ((c + 1) / 2)
                0: check_output("toggle_data", m_if.data, 32'hAAAA0000);
                1: check_output("toggle_data", m_if.data, 32'hBBBB0001);
                2: check_output("toggle_data", m_if.data, 32'hCCCC0002);
                default: check_output("toggle_data", m_if.data, 32'hDDDD0003);
            endcase
            check_output("toggle_slave_gnt", s_if.gnt, 1'b0);
        end
        @(negedge clk_i);
        s_if.req = 1'b0;
        m_if.gnt = 1'b1;
        #1;
        check_output("toggle_done", m_if.req, 1'b0);
        respond_beats(128'h00000004_00000003_00000002_00000001);

        // Three back-to-back reads; the third waits for the first wide response
        request(32'h0000_0400, 1'b1, '0, 16'hFFFF);
        check_beats(32'h0000_0400, '0, 16'hFFFF, 1'b1, 1'b1);
        request(32'h0000_0500, 1'b1, '0, 16'hFFFF);
        check_beats(32'h0000_0500, '0, 16'hFFFF, 1'b1, 1'b1);
        @(negedge clk_i);
        s_if.add = 32'h0000_0600;
        #1;
        check_output("third_blocked", s_if.gnt, 1'b0);
        check_output("third_blocked_req", m_if.req, 1'b0);
        check_output("third_blocked_busy", busy_o, 1'b1);
        repeat (2) begin
            @(negedge clk_i);
            #1;
            check_output("third_still_blocked", s_if.gnt, 1'b0);
        end
        respond_beats(128'h000000A3_000000A2_000000A1_000000A0);
        check_output("third_blocked_at_rsp", s_if.gnt, 1'b0);
        @(negedge clk_i);
        #1;
        check_output("third_granted", s_if.gnt, 1'b1);
        check_output("first_rsp_consumed", s_if.r_valid, 1'b0);
        check_beats(32'h0000_0600, '0, 16'hFFFF, 1'b1, 1'b0);

        // Upstream stalls its response ready; downstream must hold the next beat
        s_if.lrdy = 1'b0;
        respond_beats(128'h000000B3_000000B2_000000B1_000000B0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            m_if.r_valid = 1'b1;
            m_if.r_data  = 32'h000000C0;
            #1;
            check_output("stall_r_valid", s_if.r_valid, 1'b1);
            check_output("stall_r_data", s_if.r_data, 128'h000000B3_000000B2_000000B1_000000B0);
            check_output("stall_master_lrdy", m_if.lrdy, 1'b0);
        end
        @(negedge clk_i);
        s_if.lrdy = 1'b1;
        #1;
        check_output("release_master_lrdy", m_if.lrdy, 1'b1);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk_i);
            m_if.r_data = 32'h000000C0 + 32'(i);
            #1;
            check_output("post_stall_early", s_if.r_valid, 1'b0);
        end
        @(negedge clk_i);
        m_if.r_valid = 1'b0;
        #1;
        check_output("post_stall_r_valid", s_if.r_valid, 1'b1);
        check_output("post_stall_r_data", s_if.r_data, 128'h000000C3_000000C2_000000C1_000000C0);
        @(negedge clk_i);
        #1;
        check_output("post_stall_idle", busy_o, 1'b0);

        // Address wraps past the top of the address space
        single_read(32'hFFFF_FFF8, 128'h00000044_00000033_00000022_00000011);

        // Clear in the middle of beat 2 aborts the transfer
        request(32'h0000_0700, 1'b1, '0, 16'hFFFF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            s_if.req = 1'b0;
            #1;
            check_output("pre_clear_add", m_if.add, 32'h0000_0700 + 32'(4 * i));
        end
        @(negedge clk_i);
        clear_i = 1'b1;
        #1;
        check_output("clear_beat2_add", m_if.add, 32'h0000_0708);
        @(negedge clk_i);
        clear_i = 1'b0;
        #1;
        check_output("clear_master_req", m_if.req, 1'b0);
        check_output("clear_busy", busy_o, 1'b0);
        single_read(32'h0000_0800, 128'h00000008_00000007_00000006_00000005);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hci_core_serializer.md
# hci_core_serializer

Width-adapting stage placed directly upstream of the HCI core FIFO on the accelerator side. It accepts one wide HCI core request (DW_IN) from a streamer, issues it as N = DW_IN/DW_OUT consecutive narrow beats on a DW_OUT-wide HCI core master port, and collects the N in-order narrow responses into one wide response. A wide datapath can therefore drive a narrow FIFO/interconnect port with bounded outstanding transactions.

## Interface
- DW_IN, 128: slave-side data width; integer multiple of DW_OUT.
- DW_OUT, hci_package::DEFAULT_DW: master-side data width.
- BW, hci_package::DEFAULT_BW: bits per byte-enable bit.
- AW, hci_package::DEFAULT_AW: address width.
- UW, hci_package::DEFAULT_UW: user width; 0 allowed.
- MAX_OUTSTANDING, 2: maximum wide transactions accepted but not yet answered upstream; ≥1.
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- clear_i  input  1  synchronous clear; same effect as reset.
- busy_o  output  1  high while any wide transaction is in flight or a response is pending.
- tcdm_slave  hci_core_intf.slave  DW_IN  wide request/response port.
- tcdm_master  hci_core_intf.master  DW_OUT  narrow port toward the FIFO.

## Operation
- N = DW_IN/DW_OUT; BEAT_BYTES = DW_OUT/8. If N==1, the block is a pure wire passthrough.
- Request FSM states: IDLE and ISSUE.
- IDLE: slave.gnt = slave.req & (out_cnt < MAX_OUTSTANDING). On the grant cycle, capture add/data/be/wen/user into req_q, set beat=0, and move to ISSUE.
- ISSUE: master.req=1. master.add = req_q.add + beat*BEAT_BYTES, computed modulo 2^AW so the address wraps. master.data and master.be carry slice [beat] of req_q. wen and user are replicated on every beat. boffs='0.
- On master.gnt in ISSUE, beat increments. A grant of beat N-1 returns the FSM to IDLE. slave.gnt is never high in ISSUE.
- Beats with an all-zero be slice are still issued.
- Response path: each downstream beat, reads and writes alike, produces exactly one r_valid. A beat is accepted when master.r_valid & master.lrdy. Accepted beats are written into slice rsp_cnt of collect_q, and rsp_cnt wraps at N-1.
- On acceptance of beat N-1, {last beat, collect_q} moves into out_q and out_valid_q is set. out_q.user is the r_user of the last beat.
- slave.r_valid = out_valid_q. out_valid_q clears on slave.lrdy.
- master.lrdy = ~out_valid_q | slave.lrdy.
- out_cnt is the outstanding counter. It increments on upstream grant and decrements on the upstream response handshake; when both happen in the same cycle it is unchanged.
- busy_o = (state!=IDLE) | (out_cnt!=0).
- A downstream r_valid with out_cnt==0 is a protocol error. It is flagged by an assertion under ifndef SYNTHESIS.

## Timing
- Reset/clear values: state=IDLE, beat=0, rsp_cnt=0, out_cnt=0, out_valid_q=0, req_q='0, collect_q='0, out_q='0.
- Resulting output reset values: slave.gnt=0, slave.r_valid=0, slave.r_data/r_user=0, master.req=0, master.lrdy=1, busy_o=0.
- slave.gnt is combinational from slave.req and registered state.
- The first master.req appears 1 cycle after the upstream grant.
- With master.gnt tied high, the N beats take N consecutive cycles. There is one IDLE bubble between wide requests, so peak throughput is N+1 cycles per wide request.
- slave.r_valid rises 1 cycle after the last narrow beat is accepted. It is held until slave.lrdy.
- While out_valid_q=1 and slave.lrdy=0, master.lrdy=0. The downstream stage holds its response.
- clear_i mid-ISSUE aborts the remaining beats, and master.req drops the next cycle. Pending responses are discarded; the system must be quiescent downstream before clear_i is asserted.

## Structure
- Add typedef hci_serializer_state_e {IDLE, ISSUE} to hci_package.
- No sub-module. All state stays in this module, and the N==1 passthrough is selected with a generate-if.

## Test plan
All scenarios use DW_IN=128, DW_OUT=32, AW=32, BW=8, UW=0, MAX_OUTSTANDING=2.
- Single read at add=0x100, master.gnt=1 → master.add 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles. Beat responses 0xA, 0xB, 0xC, 0xD → slave.r_data=0x0000000D_0000000C_0000000B_0000000A, asserted one cycle after beat 3.
- Write at add=0x200 with be=0x00F0, data=0x44..33..22..11 words → beat1 be=0xF and data=word1; beats 0, 2 and 3 have be=0x0. One slave.r_valid after 4 downstream r_valid.
- master.gnt toggling 1,0,1,0 → each beat is held stable until granted; no beat is skipped or duplicated; slave.gnt stays 0 during ISSUE.
- Three back-to-back reads with responses delayed → third slave.gnt waits until the first slave r_valid&lrdy handshake; out_cnt never exceeds 2.
- slave.lrdy=0 for 5 cycles after a response → slave.r_valid and r_data are stable, master.lrdy=0, and the next wide response is not lost.
- Wrap: add=0xFFFFFFF8 → beats at 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- clear_i during beat 2 → master.req=0 the next cycle, busy_o=0, and a following read completes normally.
